posit64_to_fp64: RTL and testbench
==================================

# posit64_to_fp64

Pipelined converter that takes the decoded fields of a 64-bit posit (es=4) from the combinational posit decoder and packs them into an IEEE-754 binary64 word. Rounding is round-to-nearest-even. It sits directly downstream of the decoder and feeds the FP64 datapath. A valid/ready handshake applies on both sides. It is a 2-stage pipeline with a global stall.

## Interface
- `N`, 64, posit width; only the default is supported
- `RS`, 7, regime field width
- `ES`, 4, exponent field width
- `FS`, `N-3-ES` (57), fraction field width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `in_valid`  in  1  decoded posit fields valid
- `in_ready`  out  1  stage accepts input this cycle
- `in_sign`  in  1  posit sign
- `in_regi`  in  RS  regime, signed two's complement (-64..63)
- `in_expo`  in  ES  posit exponent, unsigned
- `in_frac`  in  FS  fraction magnitude, MSB-aligned, hidden 1 excluded
- `in_allzero`  in  1  posit is zero
- `in_inf`  in  1  posit is NaR
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_data`  out  64  binary64 result
- `out_inexact`  out  1  rounding, flush or saturation discarded nonzero bits

## Operation
Stage 1 registers the following on accept:
- `scale = sext(in_regi)*16 + in_expo`, a signed 12-bit value in -1024..1023
- class: ZERO if `in_allzero`; NAR if `in_inf`; otherwise NUM. `in_allzero` has priority.
- sign and frac

Stage 2 packs and rounds NUM values:
- **Normal, scale >= -1022:**
  - biased exponent = scale+1023
  - kept mantissa = frac[56:5]
  - guard = frac[4]; sticky = |frac[3:0]
- **scale = -1023:**
  - exponent field 0
  - mantissa = {1, frac[56:6]}
  - guard = frac[5]; sticky = |frac[4:0]
- **scale = -1024:**
  - exponent field 0
  - mantissa = {01, frac[56:7]}
  - guard = frac[6]; sticky = |frac[5:0]
- **RNE:**
  - increment when guard & (sticky | mantissa LSB)
  - a carry out of the mantissa increments the exponent field; a subnormal can therefore round up to the minimum normal
- **Overflow:**
  - a carry that would make the exponent field 2047 saturates to max finite, 0x7FEF_FFFF_FFFF_FFFF with sign applied
  - inexact = 1
- `out_inexact` = guard | sticky, OR'd with any saturation or flush.
- ZERO -> 0x0000_0000_0000_0000, inexact 0.
- NAR -> canonical qNaN 0x7FF8_0000_0000_0000, inexact 0, sign ignored.
- Sign bit 63 = `in_sign` for NUM.

## Timing
- Latency is 2 cycles from input acceptance to `out_valid`. Throughput is 1 per cycle.
- Global enable: `adv = !out_valid | out_ready`.
  - `in_ready = adv`, a combinational path from `out_ready`.
  - When `adv` = 0, both stages hold. `out_data` and `out_inexact` stay stable while `out_valid` is 1 and `out_ready` is 0.
  - Stage valids shift on `adv`. Bubbles propagate as `valid` = 0.
- Transfers occur only on `valid & ready`. Input fields are ignored when `in_valid` is 0.
- Asynchronous reset clears all stage valids at any point, including mid-flight; in-flight data is discarded.
- Reset values: `out_valid` 0, `out_data` 0, `out_inexact` 0. `in_ready` reads 1 during and after reset.
- Simultaneous `in_inf` and `in_allzero` resolves to ZERO.

## Configuration
- Macro `POSIT2FP_SUBNORM_EN`.
- Defined: scale -1023/-1024 produce binary64 subnormals as described above.
- Undefined: any NUM with scale < -1022 flushes to signed zero, {in_sign, 63'b0}, with `out_inexact` = 1. The subnormal shift/round logic is not built.

## Test plan
- in_allzero=1, other fields arbitrary -> out_data 0x0000000000000000 two cycles after accept, inexact 0.
- in_inf=1, in_sign=1 -> out_data 0x7FF8000000000000, inexact 0.
- sign=0, regi=0, expo=0, frac=0 -> 0x3FF0000000000000; the same with sign=1 -> 0xBFF0000000000000; regi=1, expo=3, frac=0 -> 0x4120000000000000.
- RNE, regi=0, expo=0:
  - frac=57'h10 -> 0x3FF0000000000000, inexact 1 (tie, even)
  - frac=57'h30 -> 0x3FF0000000000002, inexact 1
  - frac=57'h11 -> 0x3FF0000000000001
- regi=7'h40, expo=0, frac=0:
  - with POSIT2FP_SUBNORM_EN -> 0x0004000000000000, inexact 0
  - without -> 0x0000000000000000, inexact 1
- Saturation and backpressure:
  - regi=63, expo=15, frac=all ones -> 0x7FEFFFFFFFFFFFFF, inexact 1
  - stream 4 inputs back-to-back with out_ready held low for 3 cycles -> in_ready drops, out_data holds, no loss or duplication, order preserved
  - assert rst_n low mid-stream -> out_valid 0 immediately

Source files
------------

// File: rtl/posit64_to_fp64_if.sv
// Handshake and field bundle between the posit decoder, the converter and the FP64 datapath.
interface posit64_to_fp64_if #(
    parameter int N  = 64,
    parameter int RS = 7,
    parameter int ES = 4,
    parameter int FS = N - 3 - ES
);
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [RS-1:0] in_regi;
    logic [ES-1:0] in_expo;
    logic [FS-1:0] in_frac;
    logic          in_allzero;
    logic          in_inf;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_inexact;

    modport slave (
        input  in_valid, in_sign, in_regi, in_expo, in_frac, in_allzero, in_inf, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );

    modport master (
        output in_valid, in_sign, in_regi, in_expo, in_frac, in_allzero, in_inf, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/posit64_to_fp64.sv
// Two-stage posit64 (es=4) decoded-field to IEEE binary64 converter, round-to-nearest-even.
// POSIT2FP_SUBNORM_EN builds subnormal packing for scale -1023/-1024; otherwise those flush to signed zero.
module posit64_to_fp64 #(
    parameter int N  = 64,
    parameter int RS = 7,
    parameter int ES = 4,
    parameter int FS = N - 3 - ES
) (
    input  logic             clk,
    input  logic             rst_n,
    posit64_to_fp64_if.slave io
);
    localparam int STAGES = 2;

    typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_NAR} cls_e;

    typedef struct packed {
        logic          sign;
        cls_e          cls;
        logic [11:0]   scale;
        logic [FS-1:0] frac;
    } s1_t;

    typedef struct packed {
        logic         inexact;
        logic [N-1:0] data;
    } res_t;

    logic [STAGES:1]    vld_pipe;
    logic               adv;
    s1_t                s1_d, s1_q;
    res_t               res_d, res_q;
    logic signed [11:0] sc;
    logic [10:0]        exp_f;
    logic [51:0]        mant;
    logic               guard, sticky, flush, inc;
    logic [62:0]        mag;

    assign adv            = !vld_pipe[STAGES] || io.out_ready;
    assign io.in_ready    = adv;
    assign io.out_valid   = vld_pipe[STAGES];
    assign io.out_data    = res_q.data;
    assign io.out_inexact = res_q.inexact;

    // allzero wins over NaR when both flags are raised
    always_comb begin
        s1_d.sign  = io.in_sign;
        s1_d.cls   = io.in_allzero ? CLS_ZERO : (io.in_inf ? CLS_NAR : CLS_NUM);
        s1_d.scale = {io.in_regi[RS-1], io.in_regi, {ES{1'b0}}} + {{(12-ES){1'b0}}, io.in_expo};
        s1_d.frac  = io.in_frac;
    end

    assign sc = s1_q.scale;

    always_comb begin
        exp_f  = '0;
        mant   = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        flush  = 1'b0;
        if (sc >= -12'sd1022) begin
            exp_f  = 11'(s1_q.scale + 12'd1023);
            mant   = s1_q.frac[FS-1:5];
            guard  = s1_q.frac[4];
            sticky = |s1_q.frac[3:0];
        end
`ifdef POSIT2FP_SUBNORM_EN
        else if (sc == -12'sd1023) begin
            mant   = {1'b1, s1_q.frac[FS-1:6]};
            guard  = s1_q.frac[5];
            sticky = |s1_q.frac[4:0];
        end else begin
            mant   = {2'b01, s1_q.frac[FS-1:7]};
            guard  = s1_q.frac[6];
            sticky = |s1_q.frac[5:0];
        end
`else
        else begin
            flush = 1'b1;
        end
`endif
        // exponent and mantissa rounded as one field so a carry bumps the exponent
        inc = guard & (sticky | mant[0]);
        mag = {exp_f, mant} + 63'(inc);

        res_d.inexact = 1'b0;
        res_d.data    = '0;
        case (s1_q.cls)
            CLS_ZERO: res_d.data = '0;
            CLS_NAR:  res_d.data = 64'h7FF8_0000_0000_0000;
            default: begin
                if (flush) begin
                    res_d.data    = {s1_q.sign, 63'h0};
                    res_d.inexact = 1'b1;
                end else if (&mag[62:52]) begin
                    res_d.data    = {s1_q.sign, 63'h7FEF_FFFF_FFFF_FFFF};
                    res_d.inexact = 1'b1;
                end else begin
                    res_d.data    = {s1_q.sign, mag};
                    res_d.inexact = guard | sticky;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            res_q    <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], io.in_valid};
            if (io.in_valid)  s1_q  <= s1_d;
            if (vld_pipe[1])  res_q <= res_d;
        end
    end
endmodule

// File: tb/tb_posit64_to_fp64.sv
// Self-checking bench for posit64_to_fp64: directed table, random stream vs value model, stall and reset.
module tb_posit64_to_fp64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    posit64_to_fp64_if io();
    posit64_to_fp64 dut (.clk(clk), .rst_n(rst_n), .io(io));

    int checks = 0;
    int failures = 0;
    logic [64:0] exp_q[$];

    // Exact-value model: significand (2^57+frac) * 2^(scale-57), rounded to the binary64 grid.
    function automatic logic [64:0] ref_model(input logic s, input logic [6:0] r, input logic [3:0] e,
                                              input logic [56:0] f, input logic z, input logic n);
        int rr, scale, eff, sh;
        longint unsigned sig, q, rem, half;
        logic [10:0] fld;
        logic inx;
        if (z) return {1'b0, 64'h0};
        if (n) return {1'b0, 64'h7FF8000000000000};
        rr = int'($signed(r));
        scale = rr * 16 + int'({28'b0, e});
`ifndef POSIT2FP_SUBNORM_EN
        if (scale < -1022) return {1'b1, s, 63'h0};
`endif
        eff = (scale < -1022) ? -1022 : scale;
        sh = 5 + eff - scale;
        sig = (64'd1 << 57) | {7'b0, f};
        q = sig >> sh;
        rem = sig & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        inx = (rem != 0);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if ((q >> 53) != 0) begin
            q = q >> 1;
            eff = eff + 1;
        end
        if (q >= (64'd1 << 52) && eff + 1023 >= 2047) return {1'b1, s, 63'h7FEFFFFFFFFFFFFF};
        fld = (q < (64'd1 << 52)) ? 11'd0 : 11'(eff + 1023);
        return {inx, s, fld, q[51:0]};
    endfunction

    task automatic drive_rand();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        io.in_sign    = t[63];
        io.in_frac    = t[56:0];
        if ($urandom_range(0, 3) == 0) io.in_frac[4:0] = 5'b10000;
        if ($urandom_range(0, 7) == 0) io.in_frac = '1;
        case ($urandom_range(0, 5))
            0: io.in_regi = 7'h40;
            1: io.in_regi = 7'h3F;
            default: io.in_regi = 7'($urandom());
        endcase
        io.in_expo    = 4'($urandom());
        io.in_allzero = ($urandom_range(0, 19) == 0);
        io.in_inf     = ($urandom_range(0, 19) == 0);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (io.out_valid !== 1'b0 || io.out_data !== 64'h0 || io.out_inexact !== 1'b0 || io.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h x=%b rdy=%b want v=0 d=0 x=0 rdy=1",
                     io.out_valid, io.out_data, io.out_inexact, io.in_ready);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got v=%b rdy=%b want v=0 rdy=1", io.out_valid, io.in_ready);
        end
    endtask

    task automatic test_directed();
        logic s, z, n, x;
        logic [6:0] r;
        logic [3:0] e;
        logic [56:0] f;
        logic [63:0] d;
        int lat;
        for (int i = 0; i < 13; i++) begin
            s = 0; z = 0; n = 0; x = 0; r = 0; e = 0; f = 0; d = 64'h0;
            case (i)
                0:  begin z = 1; s = 1; r = 7'h15; e = 4'h9; f = 57'h123; end
                1:  begin n = 1; s = 1; d = 64'h7FF8000000000000; end
                2:  d = 64'h3FF0000000000000;
                3:  begin s = 1; d = 64'hBFF0000000000000; end
                4:  begin r = 7'd1; e = 4'd3; d = 64'h4120000000000000; end
                5:  begin f = 57'h10; d = 64'h3FF0000000000000; x = 1; end
                6:  begin f = 57'h30; d = 64'h3FF0000000000002; x = 1; end
                7:  begin f = 57'h11; d = 64'h3FF0000000000001; x = 1; end
`ifdef POSIT2FP_SUBNORM_EN
                8:  begin r = 7'h40; d = 64'h0004000000000000; end
                9:  begin s = 1; r = 7'h40; e = 4'd1; f = '1; d = 64'h8010000000000000; x = 1; end
`else
                8:  begin r = 7'h40; d = 64'h0000000000000000; x = 1; end
                9:  begin s = 1; r = 7'h40; e = 4'd1; f = '1; d = 64'h8000000000000000; x = 1; end
`endif
                10: begin r = 7'd63; e = 4'd15; f = '1; d = 64'h7FEFFFFFFFFFFFFF; x = 1; end
                11: begin z = 1; n = 1; s = 1; r = 7'd5; end
                default: begin r = 7'h40; e = 4'd2; d = 64'h0010000000000000; end
            endcase
            @(posedge clk); #1;
            io.in_sign = s; io.in_regi = r; io.in_expo = e; io.in_frac = f;
            io.in_allzero = z; io.in_inf = n; io.in_valid = 1'b1; io.out_ready = 1'b1;
            @(posedge clk); #1;
            io.in_valid = 1'b0;
            lat = 1;
            while (!io.out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat != 2) begin
                failures++;
                $display("FAIL dir_latency case=%0d got=%0d want=2", i, lat);
            end
            checks++;
            if (io.out_data !== d || io.out_inexact !== x) begin
                failures++;
                $display("FAIL dir_value case=%0d got d=%h x=%b want d=%h x=%b", i, io.out_data, io.out_inexact, d, x);
            end
        end
    endtask

    task automatic test_random();
        logic [64:0] e, held;
        logic stall_prev;
        int sent, cyc;
        sent = 0; cyc = 0; stall_prev = 0; held = '0;
        exp_q.delete();
        while ((sent < 300 || exp_q.size() != 0) && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (stall_prev) begin
                checks++;
                if (io.out_valid !== 1'b1 || {io.out_inexact, io.out_data} !== held) begin
                    failures++;
                    $display("FAIL rnd_hold got v=%b %h want v=1 %h", io.out_valid, {io.out_inexact, io.out_data}, held);
                end
            end
            if (sent < 300 && $urandom_range(0, 3) != 0) begin
                drive_rand();
                io.in_valid = 1'b1;
            end else begin
                io.in_valid = 1'b0;
            end
            io.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (io.in_ready !== (!io.out_valid || io.out_ready)) begin
                failures++;
                $display("FAIL rnd_in_ready got=%b want=%b", io.in_ready, !io.out_valid || io.out_ready);
            end
            if (io.out_valid && io.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_spurious got %h want no output", {io.out_inexact, io.out_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({io.out_inexact, io.out_data} !== e) begin
                        failures++;
                        $display("FAIL rnd_value got x=%b d=%h want x=%b d=%h", io.out_inexact, io.out_data, e[64], e[63:0]);
                    end
                end
            end
            if (io.in_valid && io.in_ready) begin
                exp_q.push_back(ref_model(io.in_sign, io.in_regi, io.in_expo, io.in_frac, io.in_allzero, io.in_inf));
                sent++;
            end
            stall_prev = io.out_valid && !io.out_ready;
            held = {io.out_inexact, io.out_data};
        end
        checks++;
        if (sent != 300 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rnd_drain got sent=%0d pending=%0d want sent=300 pending=0", sent, exp_q.size());
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [64:0] e, held;
        logic stall_prev, saw_block, need_new;
        int acc, got;
        acc = 0; got = 0; stall_prev = 0; saw_block = 0; need_new = 1; held = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(posedge clk); #1;
            if (stall_prev) begin
                checks++;
                if (io.out_valid !== 1'b1 || {io.out_inexact, io.out_data} !== held) begin
                    failures++;
                    $display("FAIL b2b_hold cyc=%0d got v=%b %h want v=1 %h", cyc, io.out_valid, {io.out_inexact, io.out_data}, held);
                end
            end
            if (acc < 4) begin
                if (need_new) drive_rand();
                need_new = 0;
                io.in_valid = 1'b1;
            end else begin
                io.in_valid = 1'b0;
            end
            io.out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (!io.in_ready) saw_block = 1;
            if (io.out_valid && io.out_ready) begin
                checks++;
                got++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 65'h1_DEAD_BEEF_DEAD_BEEF;
                if ({io.out_inexact, io.out_data} !== e) begin
                    failures++;
                    $display("FAIL b2b_value got x=%b d=%h want x=%b d=%h", io.out_inexact, io.out_data, e[64], e[63:0]);
                end
            end
            if (io.in_valid && io.in_ready) begin
                exp_q.push_back(ref_model(io.in_sign, io.in_regi, io.in_expo, io.in_frac, io.in_allzero, io.in_inf));
                acc++;
                need_new = 1;
            end
            stall_prev = io.out_valid && !io.out_ready;
            held = {io.out_inexact, io.out_data};
        end
        checks++;
        if (got != 4 || acc != 4 || !saw_block) begin
            failures++;
            $display("FAIL b2b_count got out=%0d in=%0d blocked=%b want out=4 in=4 blocked=1", got, acc, saw_block);
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        io.out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            drive_rand();
            io.in_allzero = 1'b0;
            io.in_inf = 1'b0;
            io.in_valid = 1'b1;
        end
        checks++;
        if (io.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got v=%b want v=1", io.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (io.out_valid !== 1'b0 || io.out_data !== 64'h0 || io.out_inexact !== 1'b0 || io.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_async got v=%b d=%h x=%b rdy=%b want v=0 d=0 x=0 rdy=1",
                     io.out_valid, io.out_data, io.out_inexact, io.in_ready);
        end
        io.in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (io.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_discard cyc=%0d got v=%b want v=0", k, io.out_valid);
            end
        end
    endtask

    initial begin
        io.in_valid = 1'b0; io.in_sign = 1'b0; io.in_regi = '0; io.in_expo = '0;
        io.in_frac = '0; io.in_allzero = 1'b0; io.in_inf = 1'b0; io.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the run completed");
        $fatal(1, "watchdog");
    end
endmodule
